return_addr_stack: RTL and testbench
====================================

// Module: return_addr_stack
// PURPOSE
//  Parametrised circular return-address stack for the IF-stage branch predictor.
//  - Call (push) saves the return address; return (pop) consumes it.
//  - Predicted target is exposed as top-of-stack every cycle.
//  - Generalises the fixed RAS_SIZE scheme to any depth and width, with overflow/underflow
//    reporting and optional misprediction checkpoint repair.
// PARAMETERS
//  DEPTH   riscv_pkg::RAS_SIZE (8)   entries; any value >= 2, need not be a power of 2
//  AW      riscv_pkg::XLEN (32)      stored address width
//  PTR_W   $clog2(DEPTH)             derived, do not override
//  CNT_W   $clog2(DEPTH+1)           derived, do not override
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  push_i         in   1      call detected: push push_addr_i
//  pop_i          in   1      return detected: pop top entry
//  push_addr_i    in   AW     return address (pc+4) to push
//  top_addr_o     out  AW     predicted return target = entry at TOS; '0 when empty
//  top_valid_o    out  1      count_o != 0
//  count_o        out  CNT_W  live entries, saturates at DEPTH
//  overflow_o     out  1      1-cycle pulse: push on full overwrote oldest entry
//  underflow_o    out  1      1-cycle pulse: pop on empty, ignored
//  ckpt_save_i    in   1      [RAS_CKPT_EN] snapshot state at branch prediction
//  ckpt_restore_i in   1      [RAS_CKPT_EN] restore snapshot on mispredict flush
// BEHAVIOUR
//  - Reset: tos=0, count=0, overflow_o=0, underflow_o=0, top_addr_o='0, top_valid_o=0.
//    Storage array is not reset; reads are masked by count.
//  - All outputs derive from registered state. An update in cycle N is visible in N+1;
//    there is no same-cycle bypass.
//  - Ops are decoded from {push_i,pop_i} and resolved in priority order:
//    - restore: overrides every other op (see CONFIGURATION).
//    - push only: tos<=inc(tos); mem[inc(tos)]<=push_addr_i; count<=min(count+1,DEPTH).
//      If count==DEPTH, the oldest entry is silently overwritten and overflow_o pulses.
//    - pop only, count>0: tos<=dec(tos); count<=count-1.
//    - pop only, count==0: no state change; underflow_o pulses.
//    - push and pop (replace, e.g. JALR rd=x1 rs1=x5): mem[tos]<=push_addr_i;
//      tos and count unchanged; no pulses. If count==0, behaves exactly as push only.
//    - none: hold state; pulses deassert.
//  - inc/dec wrap explicitly: inc(DEPTH-1)=0, dec(0)=DEPTH-1. No power-of-2 assumption.
//  - After overflow, popping DEPTH times returns the newest DEPTH addresses, then
//    top_valid_o=0. Older addresses are lost by design.
//  - Reset asserted mid-operation aborts any pending op; state returns to reset values
//    immediately.
// CONFIGURATION
//  Macro RAS_CKPT_EN:
//  - Defined: adds ckpt_save_i/ckpt_restore_i and one checkpoint register {tos,count,top}.
//    - save: captures the pre-op {tos,count,mem[tos]} of that cycle.
//    - restore: next-cycle tos/count = checkpoint values, mem[ckpt.tos]<=ckpt.top.
//      This repairs a wrong-path pop+push. The same-cycle push/pop is ignored.
//    - save and restore together: restore wins, save is dropped.
//    - Checkpoint register resets to {0,0,'0}.
//  - Undefined: ports and checkpoint register are absent; behaviour is otherwise identical.
// STRUCTURE
//  - riscv_pkg gains:
//    - ras_op_e {RAS_NONE,RAS_PUSH,RAS_POP,RAS_REPLACE}, 2 bits.
//    - RAS_SIZE, RAS_PTR_WIDTH remain the defaults.
//  - Checkpoint struct is local: width depends on DEPTH/AW.
//  - No sub-module: array, pointer, counter and checkpoint fit in one file.
// TESTING
//  1 DEPTH=8: push 0x100,0x200,0x300 -> top 0x300, count 3; pop -> top 0x200, count 2.
//  2 DEPTH=8: 9 pushes 0x4..0x24 step 4 -> overflow_o pulses once on 9th; 8 pops return
//    0x24..0x8; 9th pop -> underflow_o=1, top_valid_o=0.
//  3 push+pop together with top 0x200, addr 0x500 -> top 0x500, count unchanged;
//    same on empty -> count 1, top 0x500.
//  4 DEPTH=5 (non-pow2): 7 pushes then 5 pops -> correct wrap order, tos never >= 5.
//  5 RAS_CKPT_EN: top 0x200 count 2, save; pop, push 0xBAD; restore -> top 0x200,
//    count 2; restore+push same cycle -> push ignored.
//  6 rst_n low mid-sequence (count 4) -> outputs zero asynchronously; first push after
//    release -> count 1.

Source files
------------

// File: rtl/return_addr_stack_pkg.sv
// Shared definitions for the IF-stage return-address stack.
//   XLEN          default stored address width
//   RAS_SIZE      default stack depth
//   RAS_PTR_WIDTH pointer width for the default depth
//   ras_op_e      decoded push/pop operation
//   ras_decode    maps {push, pop} onto ras_op_e
package return_addr_stack_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned RAS_SIZE      = 8;
  localparam int unsigned RAS_PTR_WIDTH = $clog2(RAS_SIZE);

  typedef enum logic [1:0] {
    RAS_NONE    = 2'd0,
    RAS_PUSH    = 2'd1,
    RAS_POP     = 2'd2,
    RAS_REPLACE = 2'd3
  } ras_op_e;

  function automatic ras_op_e ras_decode(input logic push, input logic pop);
    ras_op_e op;
    unique case ({push, pop})
      2'b10:   op = RAS_PUSH;
      2'b01:   op = RAS_POP;
      2'b11:   op = RAS_REPLACE;
      default: op = RAS_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack for the IF-stage branch predictor.
// Calls push the return address, returns pop it; the top entry is the predicted target.
// Optional feature macro: RAS_CKPT_EN (checkpoint save/restore for mispredict repair).
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   push_i, pop_i   call / return detected (both = replace top)
//   push_addr_i     return address to push
//   top_addr_o      entry at top of stack, '0 when empty
//   top_valid_o     stack non-empty
//   count_o         live entries, saturates at DEPTH
//   overflow_o      pulse: push on full overwrote the oldest entry
//   underflow_o     pulse: pop on empty was ignored
//   ckpt_save_i     [RAS_CKPT_EN] snapshot {tos, count, top} before this cycle's op
//   ckpt_restore_i  [RAS_CKPT_EN] restore snapshot; overrides push/pop/save
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int unsigned  DEPTH = RAS_SIZE,
  parameter int unsigned  AW    = XLEN,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [AW-1:0]    push_addr_i,
`ifdef RAS_CKPT_EN
  input  logic             ckpt_save_i,
  input  logic             ckpt_restore_i,
`endif
  output logic [AW-1:0]    top_addr_o,
  output logic             top_valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  // Explicit wrap so non power-of-two depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
  endfunction

  logic [AW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [AW-1:0]    wr_data;

  logic             is_empty, is_full;
  ras_op_e          op;

  assign op       = ras_decode(push_i, pop_i);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

`ifdef RAS_CKPT_EN
  typedef struct packed {
    logic [PTR_W-1:0] tos;
    logic [CNT_W-1:0] count;
    logic [AW-1:0]    top;
  } ckpt_t;

  ckpt_t ckpt_q;
`endif

  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_ptr      = tos_q;
    wr_data     = push_addr_i;
`ifdef RAS_CKPT_EN
    if (ckpt_restore_i) begin
      // Rewriting the saved top undoes a wrong-path pop followed by a push.
      tos_d   = ckpt_q.tos;
      count_d = ckpt_q.count;
      wr_en   = 1'b1;
      wr_ptr  = ckpt_q.tos;
      wr_data = ckpt_q.top;
    end else
`endif
    begin
      unique case (op)
        RAS_PUSH, RAS_REPLACE: begin
          if (op == RAS_PUSH || is_empty) begin
            tos_d      = ptr_inc(tos_q);
            wr_en      = 1'b1;
            wr_ptr     = ptr_inc(tos_q);
            count_d    = is_full ? count_q : count_q + CNT_W'(1);
            overflow_d = is_full;
          end else begin
            // Replace: overwrite top in place, depth unchanged.
            wr_en  = 1'b1;
            wr_ptr = tos_q;
          end
        end
        RAS_POP: begin
          if (is_empty) begin
            underflow_d = 1'b1;
          end else begin
            tos_d   = ptr_dec(tos_q);
            count_d = count_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; reads are masked by count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

`ifdef RAS_CKPT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ckpt_q <= '0;
    end else if (ckpt_save_i && !ckpt_restore_i) begin
      ckpt_q <= '{tos: tos_q, count: count_q, top: mem_q[tos_q]};
    end
  end
`endif

  assign top_valid_o = !is_empty;
  assign top_addr_o  = is_empty ? '0 : mem_q[tos_q];
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_i, pop_i;
  logic [31:0] push_addr_i;
`ifdef RAS_CKPT_EN
  logic        ckpt_save, ckpt_restore;
`endif

  logic [31:0] top8, top5;
  logic        valid8, valid5, ovf8, ovf5, unf8, unf5;
  logic [3:0]  cnt8;
  logic [2:0]  cnt5;

  int checks = 0;
  int errors = 0;

  // Reference model: queue per stack, oldest at front, newest at back.
  logic [31:0] m8[$], m5[$];
  logic        e_ovf8, e_unf8, e_ovf5, e_unf5;
`ifdef RAS_CKPT_EN
  logic [31:0] s8[$], s5[$];
`endif

  always #5 clk = ~clk;

  return_addr_stack #(.DEPTH(8), .AW(32)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .push_addr_i (push_addr_i),
`ifdef RAS_CKPT_EN
    .ckpt_save_i    (ckpt_save),
    .ckpt_restore_i (ckpt_restore),
`endif
    .top_addr_o  (top8),
    .top_valid_o (valid8),
    .count_o     (cnt8),
    .overflow_o  (ovf8),
    .underflow_o (unf8)
  );

  return_addr_stack #(.DEPTH(5), .AW(32)) dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .push_addr_i (push_addr_i),
`ifdef RAS_CKPT_EN
    .ckpt_save_i    (ckpt_save),
    .ckpt_restore_i (ckpt_restore),
`endif
    .top_addr_o  (top5),
    .top_valid_o (valid5),
    .count_o     (cnt5),
    .overflow_o  (ovf5),
    .underflow_o (unf5)
  );

  function automatic logic [31:0] qtop(input logic [31:0] q[$]);
    return (q.size() != 0) ? q[q.size()-1] : 32'h0;
  endfunction

  task automatic model_apply(inout logic [31:0] q[$], input int d, input logic push,
                             input logic pop, input logic [31:0] addr,
                             output logic ovf, output logic unf);
    ovf = 1'b0;
    unf = 1'b0;
    if (push && pop && q.size() != 0) begin
      q[q.size()-1] = addr;
    end else if (push) begin
      if (q.size() == d) begin
        void'(q.pop_front());
        ovf = 1'b1;
      end
      q.push_back(addr);
    end else if (pop) begin
      if (q.size() == 0) unf = 1'b1;
      else void'(q.pop_back());
    end
  endtask

  task automatic step(input logic push, input logic pop, input logic [31:0] addr);
    push_i      = push;
    pop_i       = pop;
    push_addr_i = addr;
    model_apply(m8, 8, push, pop, addr, e_ovf8, e_unf8);
    model_apply(m5, 5, push, pop, addr, e_ovf5, e_unf5);
    @(posedge clk);
    #1;
    push_i = 1'b0;
    pop_i  = 1'b0;
  endtask

`ifdef RAS_CKPT_EN
  task automatic ckpt_step(input logic push, input logic pop, input logic [31:0] addr,
                           input logic save, input logic restore);
    ckpt_save    = save;
    ckpt_restore = restore;
    if (restore) begin
      push_i      = push;
      pop_i       = pop;
      push_addr_i = addr;
      m8 = s8;
      m5 = s5;
      {e_ovf8, e_unf8, e_ovf5, e_unf5} = '0;
      @(posedge clk);
      #1;
      push_i = 1'b0;
      pop_i  = 1'b0;
    end else begin
      if (save) begin
        s8 = m8;
        s5 = m5;
      end
      step(push, pop, addr);
    end
    ckpt_save    = 1'b0;
    ckpt_restore = 1'b0;
  endtask
`endif

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m8.delete();
    m5.delete();
    {e_ovf8, e_unf8, e_ovf5, e_unf5} = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({top8, valid8, cnt8, ovf8, unf8} !== '0) begin
      errors++;
      $display("FAIL reset_dut8 got top=%h v=%b c=%0d o=%b u=%b required all zero",
               top8, valid8, cnt8, ovf8, unf8);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({top5, valid5, cnt5, ovf5, unf5} !== '0) begin
      errors++;
      $display("FAIL reset_dut5 got top=%h v=%b c=%0d o=%b u=%b required all zero",
               top5, valid5, cnt5, ovf5, unf5);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] addrs[3] = '{32'h100, 32'h200, 32'h300};
    do_reset();
    foreach (addrs[i]) step(1'b1, 1'b0, addrs[i]);
    checks++;
    if (top8 !== 32'h300 || cnt8 !== 4'd3 || valid8 !== 1'b1) begin
      errors++;
      $display("FAIL basic_push got top=%h c=%0d v=%b required top=300 c=3 v=1",
               top8, cnt8, valid8);
    end
    step(1'b0, 1'b1, 32'h0);
    checks++;
    if (top8 !== 32'h200 || cnt8 !== 4'd2) begin
      errors++;
      $display("FAIL basic_pop got top=%h c=%0d required top=200 c=2", top8, cnt8);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 32'(4 * (i + 1)));
      checks++;
      if (ovf8 !== (i == 8)) begin
        errors++;
        $display("FAIL ovf_pulse push %0d got %b required %b", i + 1, ovf8, (i == 8));
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (top8 !== 32'(32'h24 - 4 * i) || valid8 !== 1'b1) begin
        errors++;
        $display("FAIL ovf_pop_order pop %0d got top=%h v=%b required top=%h v=1",
                 i, top8, valid8, 32'(32'h24 - 4 * i));
      end
      step(1'b0, 1'b1, 32'h0);
    end
    checks++;
    if (valid8 !== 1'b0 || cnt8 !== 4'd0 || top8 !== 32'h0) begin
      errors++;
      $display("FAIL ovf_drained got v=%b c=%0d top=%h required 0 0 0", valid8, cnt8, top8);
    end
    step(1'b0, 1'b1, 32'h0);
    checks++;
    if (unf8 !== 1'b1 || valid8 !== 1'b0) begin
      errors++;
      $display("FAIL underflow got u=%b v=%b required u=1 v=0", unf8, valid8);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (unf8 !== 1'b0) begin
      errors++;
      $display("FAIL underflow_pulse got %b required 0", unf8);
    end
  endtask

  task automatic test_replace();
    do_reset();
    step(1'b1, 1'b0, 32'h100);
    step(1'b1, 1'b0, 32'h200);
    step(1'b1, 1'b1, 32'h500);
    checks++;
    if (top8 !== 32'h500 || cnt8 !== 4'd2 || ovf8 !== 1'b0 || unf8 !== 1'b0) begin
      errors++;
      $display("FAIL replace got top=%h c=%0d o=%b u=%b required top=500 c=2 o=0 u=0",
               top8, cnt8, ovf8, unf8);
    end
    step(1'b0, 1'b1, 32'h0);
    checks++;
    if (top8 !== 32'h100 || cnt8 !== 4'd1) begin
      errors++;
      $display("FAIL replace_below got top=%h c=%0d required top=100 c=1", top8, cnt8);
    end
    do_reset();
    step(1'b1, 1'b1, 32'h500);
    checks++;
    if (top8 !== 32'h500 || cnt8 !== 4'd1 || valid8 !== 1'b1) begin
      errors++;
      $display("FAIL replace_empty got top=%h c=%0d v=%b required top=500 c=1 v=1",
               top8, cnt8, valid8);
    end
  endtask

  task automatic test_nonpow2();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 32'(16 * (i + 1)));
      checks++;
      if (ovf5 !== (i >= 5) || dut5.tos_q >= 3'd5) begin
        errors++;
        $display("FAIL np2_push %0d got o=%b tos=%0d required o=%b tos<5",
                 i, ovf5, dut5.tos_q, (i >= 5));
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (top5 !== 32'(32'h70 - 16 * i) || cnt5 !== 3'(5 - i)) begin
        errors++;
        $display("FAIL np2_pop %0d got top=%h c=%0d required top=%h c=%0d",
                 i, top5, cnt5, 32'(32'h70 - 16 * i), 5 - i);
      end
      step(1'b0, 1'b1, 32'h0);
      checks++;
      if (dut5.tos_q >= 3'd5) begin
        errors++;
        $display("FAIL np2_tos got %0d required <5", dut5.tos_q);
      end
    end
    checks++;
    if (valid5 !== 1'b0 || top5 !== 32'h0) begin
      errors++;
      $display("FAIL np2_empty got v=%b top=%h required v=0 top=0", valid5, top5);
    end
  endtask

  task automatic test_random();
    int unsigned r;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = $urandom_range(0, 9);
      step(r < 4 || r == 7, (r >= 4 && r <= 7), $urandom & 32'hffff_fffc);
      checks++;
      if ({top8, valid8, cnt8, ovf8, unf8} !==
          {qtop(m8), m8.size() != 0, 4'(m8.size()), e_ovf8, e_unf8}) begin
        errors++;
        $display("FAIL rand_dut8 cyc %0d got %h/%b/%0d/%b/%b required %h/%b/%0d/%b/%b",
                 cyc, top8, valid8, cnt8, ovf8, unf8,
                 qtop(m8), m8.size() != 0, m8.size(), e_ovf8, e_unf8);
      end
      checks++;
      if ({top5, valid5, cnt5, ovf5, unf5} !==
          {qtop(m5), m5.size() != 0, 3'(m5.size()), e_ovf5, e_unf5}) begin
        errors++;
        $display("FAIL rand_dut5 cyc %0d got %h/%b/%0d/%b/%b required %h/%b/%0d/%b/%b",
                 cyc, top5, valid5, cnt5, ovf5, unf5,
                 qtop(m5), m5.size() != 0, m5.size(), e_ovf5, e_unf5);
      end
    end
  endtask

`ifdef RAS_CKPT_EN
  task automatic test_ckpt();
    do_reset();
    ckpt_step(1'b1, 1'b0, 32'h100, 1'b0, 1'b0);
    ckpt_step(1'b1, 1'b0, 32'h200, 1'b0, 1'b0);
    ckpt_step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    ckpt_step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    ckpt_step(1'b1, 1'b0, 32'hBAD, 1'b0, 1'b0);
    checks++;
    if (top8 !== 32'hBAD) begin
      errors++;
      $display("FAIL ckpt_wrongpath got top=%h required bad", top8);
    end
    ckpt_step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (top8 !== 32'h200 || cnt8 !== 4'd2 || top8 !== qtop(m8)) begin
      errors++;
      $display("FAIL ckpt_restore got top=%h c=%0d required top=200 c=2", top8, cnt8);
    end
    ckpt_step(1'b1, 1'b0, 32'h777, 1'b1, 1'b1);
    checks++;
    if (top8 !== 32'h200 || cnt8 !== 4'd2 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL ckpt_restore_push got top=%h c=%0d o=%b required top=200 c=2 o=0",
               top8, cnt8, ovf8);
    end
    ckpt_step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    checks++;
    if (top8 !== 32'h100 || cnt8 !== 4'd1) begin
      errors++;
      $display("FAIL ckpt_below got top=%h c=%0d required top=100 c=1", top8, cnt8);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(32'h1000 + 4 * i));
    checks++;
    if (cnt8 !== 4'd4) begin
      errors++;
      $display("FAIL arst_pre got c=%0d required 4", cnt8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({top8, valid8, cnt8, top5, valid5, cnt5} !== '0) begin
      errors++;
      $display("FAIL arst_async got top8=%h v8=%b c8=%0d top5=%h v5=%b c5=%0d required zero",
               top8, valid8, cnt8, top5, valid5, cnt5);
    end
    push_i      = 1'b1;
    push_addr_i = 32'hDEAD;
    @(posedge clk);
    #1;
    push_i = 1'b0;
    checks++;
    if (cnt8 !== 4'd0 || valid8 !== 1'b0) begin
      errors++;
      $display("FAIL arst_hold got c=%0d v=%b required 0 0", cnt8, valid8);
    end
    rst_n = 1'b1;
    m8.delete();
    m5.delete();
    step(1'b1, 1'b0, 32'h40);
    checks++;
    if (cnt8 !== 4'd1 || top8 !== 32'h40 || cnt5 !== 3'd1) begin
      errors++;
      $display("FAIL arst_after got c8=%0d top=%h c5=%0d required 1 40 1", cnt8, top8, cnt5);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    push_i      = 1'b0;
    pop_i       = 1'b0;
    push_addr_i = 32'h0;
`ifdef RAS_CKPT_EN
    ckpt_save    = 1'b0;
    ckpt_restore = 1'b0;
`endif
    test_reset();
    test_basic();
    test_overflow();
    test_replace();
    test_nonpow2();
    test_random();
`ifdef RAS_CKPT_EN
    test_ckpt();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
